tdc_event_collector: RTL and testbench

Multi-channel readout stage for the TDC array. It captures the final measurement word from N_CH independent TDC channels on each channel's done pulse and tags it with a channel ID and a coarse timestamp. Captured words are serialised through round-robin arbitration into a first-word-fall-through FIFO with a valid/ready output toward the readout or UART path. It runs entirely in the clk0 domain, downstream of each TDC channel's merging stage.

---
 rtl/tdc_event_collector_if.sv | 33 +++
 rtl/tdc_event_collector.sv | 129 ++++++++++++
 tb/tb_tdc_event_collector.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_event_collector_if.sv
// Capture-side and FWFT readout signals of the TDC event collector.
// master drives captures and iReady; slave is the collector.
interface tdc_event_collector_if #(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 32,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 16
);
    localparam int CH_W  = $clog2(N_CH) + 1;
    localparam int OUT_W = TS_W + CH_W + DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                     iEnable;
    logic [N_CH-1:0]          iDone;
    logic [N_CH*DATA_W-1:0]   iTDC;
    logic                     iReady;
    logic                     iClearErr;
    logic [OUT_W-1:0]         oData;
    logic                     oValid;
    logic [CNT_W-1:0]         oCount;
    logic [N_CH-1:0]          oLost;
    logic                     oOverflow;

    modport slave (
        input  iEnable, iDone, iTDC, iReady, iClearErr,
        output oData, oValid, oCount, oLost, oOverflow
    );

    modport master (
        output iEnable, iDone, iTDC, iReady, iClearErr,
        input  oData, oValid, oCount, oLost, oOverflow
    );
endinterface

// File: rtl/tdc_event_collector.sv
// Multi-channel TDC readout: per-channel hold, round-robin arbiter, FWFT FIFO.
// Optional epoch markers on timestamp wrap: TDC_EPOCH_MARK_EN.
module tdc_event_collector #(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 32,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 16
) (
    input logic                clk0,
    input logic                iRst,
    tdc_event_collector_if.slave bus
);
    localparam int IDX_W = $clog2(N_CH);
    localparam int CH_W  = IDX_W + 1;
    localparam int OUT_W = TS_W + CH_W + DATA_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    logic [TS_W-1:0]  ts;
    logic [N_CH-1:0]  pend;
    logic [N_CH-1:0]  cap;
    logic [N_CH-1:0]  gnt_vec;
    logic [N_CH-1:0]  lost;
    logic [OUT_W-1:0] hold [N_CH];
    logic [IDX_W-1:0] rr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] cand;
    logic             gnt_any;
    logic             full;
    logic             grant;
    logic             epoch;
    logic             wr_en;
    logic             rd_en;
    logic [OUT_W-1:0] wr_data;
    logic [OUT_W-1:0] marker;
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CNT_W-1:0] count;

    assign cap    = bus.iDone & {N_CH{bus.iEnable}};
    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign marker = {{TS_W{1'b0}}, {CH_W{1'b1}}, {DATA_W{1'b0}}};

`ifdef TDC_EPOCH_MARK_EN
    logic ovf;

    // The edge that wraps ts to zero carries the marker
    assign epoch         = &ts;
    assign bus.oOverflow = ovf;

    always_ff @(posedge clk0 or posedge iRst) begin
        if (iRst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= (ovf & ~bus.iClearErr) | (epoch & full);
        end
    end
`else
    assign epoch         = 1'b0;
    assign bus.oOverflow = 1'b0;
`endif

    // Search starts one past the last granted channel
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = IDX_W'((int'(rr) + i) % N_CH);
            if (!gnt_any && pend[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign grant   = gnt_any && !full && !epoch;
    assign wr_en   = grant || (epoch && !full);
    assign wr_data = epoch ? marker : hold[gnt_idx];
    assign rd_en   = bus.oValid && bus.iReady;

    always_comb begin
        gnt_vec = '0;
        if (grant) gnt_vec[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk0 or posedge iRst) begin
        if (iRst) begin
            ts    <= '0;
            pend  <= '0;
            lost  <= '0;
            rr    <= IDX_W'(N_CH - 1);
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            ts    <= ts + TS_W'(1);
            pend  <= cap | (pend & ~gnt_vec);
            lost  <= (bus.iClearErr ? '0 : lost) | (cap & pend & ~gnt_vec);
            if (grant) rr <= gnt_idx;
            if (wr_en) wptr <= wptr + AW'(1);
            if (rd_en) rptr <= rptr + AW'(1);
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clk0 or posedge iRst) begin
        if (iRst) begin
            for (int k = 0; k < N_CH; k++) hold[k] <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (cap[k]) begin
                    hold[k] <= {ts, 1'b0, IDX_W'(k),
                                bus.iTDC[k*DATA_W +: DATA_W]};
                end
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (wr_en) mem[wptr] <= wr_data;
    end

    assign bus.oValid = (count != '0);
    assign bus.oData  = bus.oValid ? mem[rptr] : '0;
    assign bus.oCount = count;
    assign bus.oLost  = lost;
endmodule

// File: tb/tb_tdc_event_collector.sv
// Directed bench for tdc_event_collector with a queue scoreboard.
// Epoch-marker scenarios run when TDC_EPOCH_MARK_EN is defined.
module tb_tdc_event_collector;
`ifdef TDC_EPOCH_MARK_EN
    localparam int TS_W = 4;
`else
    localparam int TS_W = 16;
`endif
    localparam int N_CH   = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int OUT_W  = TS_W + 3 + DATA_W;

    logic clk0 = 1'b0;
    logic iRst = 1'b1;
    always #5 clk0 = ~clk0;

    tdc_event_collector_if #(
        .N_CH(N_CH), .DATA_W(DATA_W), .TS_W(TS_W), .FIFO_DEPTH(DEPTH)
    ) bus ();

    tdc_event_collector #(
        .N_CH(N_CH), .DATA_W(DATA_W), .TS_W(TS_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk0(clk0),
        .iRst(iRst),
        .bus (bus.slave)
    );

    logic [TS_W-1:0]  tb_ts;
    logic [OUT_W-1:0] exp_q [$];
    int passed = 0;
    int total  = 0;
    int cyc;

    // Reference timestamp: the value the DUT uses at the next edge
    always @(posedge clk0 or posedge iRst)
        if (iRst) tb_ts <= '0;
        else      tb_ts <= tb_ts + 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic logic [OUT_W-1:0] word(input int ch,
            input logic [31:0] d, input logic [TS_W-1:0] t);
        logic [1:0] c;
        c = ch[1:0];
        return {t, 1'b0, c, d};
    endfunction

    task automatic tick;
        @(negedge clk0);
    endtask

    task automatic do_reset;
        iRst = 1'b1;
        bus.iDone = '0;
        bus.iReady = 1'b0;
        bus.iClearErr = 1'b0;
        exp_q.delete();
        repeat (2) tick;
        iRst = 1'b0;
    endtask

    task automatic drain(input int budget, output int cycles);
        int n;
        int got;
        logic [OUT_W-1:0] e;
        n = exp_q.size();
        got = 0;
        cycles = 0;
        bus.iReady = 1'b1;
        while (got < n && cycles < budget) begin
            if (bus.oValid) begin
                e = exp_q.pop_front();
                chk("sb_word", 64'(bus.oData), 64'(e));
                got++;
            end
            tick;
            cycles++;
        end
        chk("drain_count", 64'(got), 64'(n));
        chk("drain_empty", 64'(bus.oValid), 64'(0));
    endtask

    initial begin
        logic [OUT_W-1:0] mk;
        bus.iEnable = 1'b0;
        bus.iDone = '0;
        bus.iTDC = '0;
        bus.iReady = 1'b0;
        bus.iClearErr = 1'b0;
        mk = {{TS_W{1'b0}}, 3'b111, 32'h0};

        tick;
        chk("rst_valid", 64'(bus.oValid), 64'(0));
        chk("rst_count", 64'(bus.oCount), 64'(0));
        chk("rst_data", 64'(bus.oData), 64'(0));
        chk("rst_lost", 64'(bus.oLost), 64'(0));
        chk("rst_ovf", 64'(bus.oOverflow), 64'(0));
        do_reset();

`ifdef TDC_EPOCH_MARK_EN
        repeat (15) tick;
        chk("pre_wrap_count", 64'(bus.oCount), 64'(0));
        tick;
        chk("marker_count", 64'(bus.oCount), 64'(1));
        chk("marker_word", 64'(bus.oData), 64'(mk));
        repeat (240) tick;
        chk("full_count", 64'(bus.oCount), 64'(16));
        chk("ovf_not_yet", 64'(bus.oOverflow), 64'(0));
        repeat (16) tick;
        chk("ovf_set", 64'(bus.oOverflow), 64'(1));
        chk("full_hold", 64'(bus.oCount), 64'(16));
        bus.iClearErr = 1'b1;
        tick;
        bus.iClearErr = 1'b0;
        chk("ovf_clear", 64'(bus.oOverflow), 64'(0));
        repeat (17) exp_q.push_back(mk);
        drain(60, cyc);
`else
        // Single pulse on channel 2 at ts=5
        bus.iEnable = 1'b1;
        repeat (5) tick;
        bus.iTDC[2*32 +: 32] = 32'hA5A5_0001;
        bus.iDone = 4'b0100;
        exp_q.push_back(word(2, 32'hA5A5_0001, tb_ts));
        tick;
        bus.iDone = '0;
        chk("lat_one_edge", 64'(bus.oValid), 64'(0));
        tick;
        chk("lat_two_edges", 64'(bus.oValid), 64'(1));
        chk("first_word", 64'(bus.oData),
            64'({16'd5, 3'b010, 32'hA5A5_0001}));
        chk("first_count", 64'(bus.oCount), 64'(1));
        drain(10, cyc);

        // Capture disabled
        bus.iEnable = 1'b0;
        bus.iDone = 4'b1111;
        tick;
        bus.iDone = '0;
        repeat (3) tick;
        chk("enable_low", 64'(bus.oCount), 64'(0));

        // All four channels in one cycle, fresh priority
        do_reset();
        bus.iEnable = 1'b1;
        bus.iReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.iTDC[k*32 +: 32] = 32'hD000_0000 + k;
            exp_q.push_back(word(k, 32'hD000_0000 + k, tb_ts));
        end
        bus.iDone = 4'b1111;
        tick;
        bus.iDone = '0;
        drain(20, cyc);
        chk("burst_cycles", 64'(cyc), 64'(5));

        // Backpressure: 20 back-to-back captures on channel 0
        bus.iReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.iTDC[31:0] = 32'hC000_0000 + i;
            bus.iDone = 4'b0001;
            if (i < 16 || i == 19)
                exp_q.push_back(word(0, 32'hC000_0000 + i, tb_ts));
            tick;
        end
        bus.iDone = '0;
        chk("sat_count", 64'(bus.oCount), 64'(16));
        chk("sat_lost", 64'(bus.oLost), 64'(4'b0001));
        chk("sat_ovf", 64'(bus.oOverflow), 64'(0));
        drain(40, cyc);
        chk("lost_sticky", 64'(bus.oLost), 64'(4'b0001));
        bus.iClearErr = 1'b1;
        tick;
        bus.iClearErr = 1'b0;
        chk("lost_clear", 64'(bus.oLost), 64'(0));

        // Capture on channel 1 in its grant cycle
        bus.iReady = 1'b1;
        bus.iTDC[63:32] = 32'h1111_0001;
        bus.iDone = 4'b0010;
        exp_q.push_back(word(1, 32'h1111_0001, tb_ts));
        tick;
        bus.iTDC[63:32] = 32'h1111_0002;
        exp_q.push_back(word(1, 32'h1111_0002, tb_ts));
        tick;
        bus.iDone = '0;
        drain(10, cyc);
        chk("regrant_no_lost", 64'(bus.oLost), 64'(0));

        // Rotation continues after channel 1
        for (int k = 0; k < 4; k++)
            bus.iTDC[k*32 +: 32] = 32'hE000_0000 + k;
        for (int j = 2; j < 6; j++)
            exp_q.push_back(word(j % 4, 32'hE000_0000 + (j % 4), tb_ts));
        bus.iDone = 4'b1111;
        tick;
        bus.iDone = '0;
        drain(20, cyc);
        chk("rr_cycles", 64'(cyc), 64'(5));

        // Asynchronous reset in the middle of a burst
        bus.iReady = 1'b0;
        bus.iDone = 4'b1111;
        repeat (6) tick;
        chk("burst_lost", 64'(bus.oLost != '0), 64'(1));
        #1;
        iRst = 1'b1;
        bus.iDone = '0;
        exp_q.delete();
        #2;
        chk("arst_valid", 64'(bus.oValid), 64'(0));
        chk("arst_count", 64'(bus.oCount), 64'(0));
        chk("arst_lost", 64'(bus.oLost), 64'(0));
        #3;
        iRst = 1'b0;
        repeat (3) tick;
        chk("arst_pend", 64'(bus.oValid), 64'(0));
        bus.iTDC[127:96] = 32'h3333_0003;
        bus.iDone = 4'b1000;
        exp_q.push_back(word(3, 32'h3333_0003, tb_ts));
        tick;
        bus.iDone = '0;
        drain(10, cyc);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
